// File: rtl/periodic_framing_pkg.sv
// Shared definitions for the periodic framing blocks.
// Holds:
//   - the 3-bit FSM state encoding
//   - the default settings-bus addresses
//   - the 16-bit saturating counter width and a helper that increments
//     without wrapping
package periodic_framing_pkg;

  localparam int          CNT_W   = 16;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  localparam logic [7:0] SR_FRAME_LEN_DEF          = 8'd0;
  localparam logic [7:0] SR_GAP_LEN_DEF            = 8'd1;
  localparam logic [7:0] SR_OFFSET_DEF             = 8'd2;
  localparam logic [7:0] SR_NUMBER_SYMBOLS_MAX_DEF = 8'd3;
  localparam logic [7:0] SR_FILL_VALUE_DEF         = 8'd4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_OFFSET = 3'd1;
  localparam logic [2:0] ST_FRAME  = 3'd2;
  localparam logic [2:0] ST_PAD    = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [2:0] ST_GAP    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_OFFSET = ST_OFFSET,
    S_FRAME  = ST_FRAME,
    S_PAD    = ST_PAD,
    S_DRAIN  = ST_DRAIN,
    S_GAP    = ST_GAP
  } state_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/periodic_deframer_if.sv
// AXI-stream style sample bus with an end-of-burst sideband.
// Signals:
//   tdata  - sample word
//   tlast  - end of frame
//   tvalid - beat is valid
//   tready - sink can accept the beat
//   eof    - last frame of a burst, meaningful on the tlast beat
// Modports:
//   master - drives the bus
//   slave  - receives the bus
interface periodic_deframer_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] tdata;
  logic             tlast;
  logic             tvalid;
  logic             tready;
  logic             eof;

  modport master (output tdata, output tlast, output tvalid, output eof, input tready);
  modport slave  (input tdata, input tlast, input tvalid, input eof, output tready);
endinterface

// File: rtl/setting_reg.sv
// Single settings-bus register: captures data when the strobe hits its address.
// Ports:
//   clk, rst_n     - clock and asynchronous active-low reset
//   clear          - synchronous clear back to the reset value
//   strobe, addr   - settings bus write strobe and address
//   data           - settings bus write data (already narrowed to WIDTH)
//   value          - current register contents
module setting_reg #(
  parameter logic [7:0]       MY_ADDR  = 8'd0,
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] AT_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             strobe,
  input  logic [7:0]       addr,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] value
);

  // Register update: reset/clear to AT_RESET, load on an addressed write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= AT_RESET;
    end else if (clear) begin
      value <= AT_RESET;
    end else if (strobe && (addr == MY_ADDR)) begin
      value <= data;
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/periodic_deframer.sv
// Periodic deframer.
// Turns tlast-delimited symbol frames into a continuous sample stream.
//
// Each burst is laid out as:
//   - `offset` fill samples
//   - then every frame padded or truncated to `frame_len`
//   - with `gap_len` fill samples between frames
//
// A burst ends on the input eof flag or after `numsymbols_max` frames.
//
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   clear               - synchronous clear, same effect as reset
//   set_stb/addr/data   - settings bus
//   stream_i            - input frames (slave), eof sampled on the tlast beat
//   stream_o            - output sample stream (master), eof driven low
//   trigger_o_tvalid    - mirrors stream_o.tvalid
//   trigger_o_tlast     - marks the first output sample of a burst
//   err_short, err_long - one-cycle pulses, registered, for frames that were
//                         padded (short) or truncated (long)
//
// Build option: define PERIODIC_DEFRAMER_FILL_REG_EN to add a programmable
// fill word at SR_FILL_VALUE. Without it, fill samples are zero.
module periodic_deframer
  import periodic_framing_pkg::*;
#(
  parameter logic [7:0] SR_FRAME_LEN          = SR_FRAME_LEN_DEF,
  parameter logic [7:0] SR_GAP_LEN            = SR_GAP_LEN_DEF,
  parameter logic [7:0] SR_OFFSET             = SR_OFFSET_DEF,
  parameter logic [7:0] SR_NUMBER_SYMBOLS_MAX = SR_NUMBER_SYMBOLS_MAX_DEF,
  parameter logic [7:0] SR_FILL_VALUE         = SR_FILL_VALUE_DEF,
  parameter int         WIDTH                 = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 set_stb,
  input  logic [7:0]           set_addr,
  input  logic [31:0]          set_data,
  periodic_deframer_if.slave   stream_i,
  periodic_deframer_if.master  stream_o,
  output logic                 trigger_o_tvalid,
  output logic                 trigger_o_tlast,
  output logic                 err_short,
  output logic                 err_long
);

  logic [15:0]      frame_len, gap_len, offset_len, num_max, fl_eff;
  logic [WIDTH-1:0] fill;

  setting_reg #(.MY_ADDR(SR_FRAME_LEN), .WIDTH(16)) sr_frame_len (
    .clk(clk), .rst_n(reset_n), .clear(clear), .strobe(set_stb), .addr(set_addr),
    .data(set_data[15:0]), .value(frame_len));
  setting_reg #(.MY_ADDR(SR_GAP_LEN), .WIDTH(16)) sr_gap_len (
    .clk(clk), .rst_n(reset_n), .clear(clear), .strobe(set_stb), .addr(set_addr),
    .data(set_data[15:0]), .value(gap_len));
  setting_reg #(.MY_ADDR(SR_OFFSET), .WIDTH(16)) sr_offset (
    .clk(clk), .rst_n(reset_n), .clear(clear), .strobe(set_stb), .addr(set_addr),
    .data(set_data[15:0]), .value(offset_len));
  setting_reg #(.MY_ADDR(SR_NUMBER_SYMBOLS_MAX), .WIDTH(16)) sr_num_max (
    .clk(clk), .rst_n(reset_n), .clear(clear), .strobe(set_stb), .addr(set_addr),
    .data(set_data[15:0]), .value(num_max));

`ifdef PERIODIC_DEFRAMER_FILL_REG_EN
  setting_reg #(.MY_ADDR(SR_FILL_VALUE), .WIDTH(WIDTH)) sr_fill (
    .clk(clk), .rst_n(reset_n), .clear(clear), .strobe(set_stb), .addr(set_addr),
    .data(set_data[WIDTH-1:0]), .value(fill));
`else
  assign fill = '0;
  logic unused_set_data;
  assign unused_set_data = ^set_data[31:16];
`endif

  // A zero frame length would never terminate a frame, so treat it as one.
  assign fl_eff = (frame_len == 16'd0) ? 16'd1 : frame_len;

  state_t      state, state_nxt;
  logic [15:0] counter, counter_nxt;
  logic [15:0] frames, frames_nxt;
  logic        eof_l, eof_nxt;
  logic        first, first_nxt;
  logic        short_nxt, long_nxt;
  logic        eof_now, limit_hit, burst_end, period_end, frame_done;
  logic        o_tvalid, o_tlast, i_tready;
  logic [WIDTH-1:0] o_tdata;

  // End-of-burst flag for the frame currently finishing.
  // It comes live from the input on a tlast beat, otherwise from the latch.
  // A truncated frame's eof is not known until its tlast is drained, so its
  // last emitted sample cannot be marked by eof.
  always_comb begin
    if ((state == S_FRAME) || (state == S_DRAIN)) begin
      eof_now = stream_i.tlast & stream_i.eof;
    end else begin
      eof_now = eof_l;
    end
  end

  assign limit_hit  = (num_max != 16'd0) && (({1'b0, frames} + 17'd1) >= {1'b0, num_max});
  assign burst_end  = eof_now | limit_hit;
  assign period_end = (gap_len == 16'd0) | burst_end;

  // Next-state, counters and stream outputs for the burst FSM.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    frames_nxt  = frames;
    eof_nxt     = eof_l;
    first_nxt   = first;
    short_nxt   = 1'b0;
    long_nxt    = 1'b0;
    frame_done  = 1'b0;
    o_tvalid    = 1'b0;
    o_tdata     = '0;
    o_tlast     = 1'b0;
    i_tready    = 1'b0;

    case (state)
      S_IDLE: begin
        if (stream_i.tvalid) begin
          counter_nxt = 16'd1;
          frames_nxt  = 16'd0;
          eof_nxt     = 1'b0;
          first_nxt   = 1'b1;
          state_nxt   = (offset_len != 16'd0) ? S_OFFSET : S_FRAME;
        end else begin
          state_nxt = S_IDLE;
        end
      end

      S_OFFSET: begin
        o_tvalid = 1'b1;
        o_tdata  = fill;
        if (stream_o.tready) begin
          if (counter >= offset_len) begin
            state_nxt   = S_FRAME;
            counter_nxt = 16'd1;
          end else begin
            counter_nxt = sat_inc(counter);
          end
        end else begin
          counter_nxt = counter;
        end
      end

      S_FRAME: begin
        o_tvalid = stream_i.tvalid;
        o_tdata  = stream_i.tdata;
        i_tready = stream_o.tready;
        o_tlast  = (counter >= fl_eff) ? period_end : 1'b0;
        if (stream_i.tvalid && stream_o.tready) begin
          if (stream_i.tlast) begin
            eof_nxt = stream_i.eof;
            if (counter >= fl_eff) begin
              frame_done = 1'b1;
            end else begin
              state_nxt   = S_PAD;
              short_nxt   = 1'b1;
              counter_nxt = sat_inc(counter);
            end
          end else if (counter >= fl_eff) begin
            // Output frame is complete; the rest of the input frame is dropped.
            long_nxt  = 1'b1;
            state_nxt = S_DRAIN;
          end else begin
            counter_nxt = sat_inc(counter);
          end
        end else begin
          counter_nxt = counter;
        end
      end

      S_PAD: begin
        o_tvalid = 1'b1;
        o_tdata  = fill;
        o_tlast  = (counter >= fl_eff) ? period_end : 1'b0;
        if (stream_o.tready) begin
          if (counter >= fl_eff) begin
            frame_done = 1'b1;
          end else begin
            counter_nxt = sat_inc(counter);
          end
        end else begin
          counter_nxt = counter;
        end
      end

      S_DRAIN: begin
        i_tready = 1'b1;
        if (stream_i.tvalid && stream_i.tlast) begin
          eof_nxt    = stream_i.eof;
          frame_done = 1'b1;
        end else begin
          eof_nxt = eof_l;
        end
      end

      S_GAP: begin
        o_tvalid = 1'b1;
        o_tdata  = fill;
        o_tlast  = (counter >= gap_len);
        if (stream_o.tready) begin
          if (counter >= gap_len) begin
            state_nxt   = S_FRAME;
            counter_nxt = 16'd1;
          end else begin
            counter_nxt = sat_inc(counter);
          end
        end else begin
          counter_nxt = counter;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (frame_done) begin
      frames_nxt  = sat_inc(frames);
      counter_nxt = 16'd1;
      if (burst_end) begin
        state_nxt = S_IDLE;
      end else if (gap_len == 16'd0) begin
        state_nxt = S_FRAME;
      end else begin
        state_nxt = S_GAP;
      end
    end else begin
      frames_nxt = frames_nxt;
    end

    if (o_tvalid && stream_o.tready) begin
      first_nxt = 1'b0;
    end else begin
      first_nxt = first_nxt;
    end
  end

  // FSM state, counters and registered error pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      counter   <= 16'd0;
      frames    <= 16'd0;
      eof_l     <= 1'b0;
      first     <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else if (clear) begin
      state     <= S_IDLE;
      counter   <= 16'd0;
      frames    <= 16'd0;
      eof_l     <= 1'b0;
      first     <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      state     <= state_nxt;
      counter   <= counter_nxt;
      frames    <= frames_nxt;
      eof_l     <= eof_nxt;
      first     <= first_nxt;
      err_short <= short_nxt;
      err_long  <= long_nxt;
    end
  end

  assign stream_o.tvalid = o_tvalid;
  assign stream_o.tdata  = o_tdata;
  assign stream_o.tlast  = o_tlast;
  assign stream_o.eof    = 1'b0;
  assign stream_i.tready = i_tready;
  assign trigger_o_tvalid = o_tvalid;
  assign trigger_o_tlast  = o_tvalid & first;

endmodule

// File: tb/tb_periodic_deframer.sv
// Self-checking bench for periodic_deframer.
// The expected output of each scenario is computed from the frame list and
// the settings, then compared beat by beat with what the DUT emits under
// random backpressure and input bubbles.
module tb_periodic_deframer;
  import periodic_framing_pkg::*;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  logic        trig_tvalid, trig_tlast, err_short, err_long;

  periodic_deframer_if #(.WIDTH(W)) s_in ();
  periodic_deframer_if #(.WIDTH(W)) s_out ();

  periodic_deframer #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .stream_i(s_in), .stream_o(s_out),
    .trigger_o_tvalid(trig_tvalid), .trigger_o_tlast(trig_tlast),
    .err_short(err_short), .err_long(err_long));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int c_flen, c_gap, c_off, c_max;
  logic [31:0] c_fill;
  int fr_len[$];
  bit fr_eof[$];
  logic [31:0] in_data[$];
  bit in_last[$];
  bit in_eof[$];
  logic [31:0] ex_data[$];
  bit ex_last[$];
  bit ex_trig[$];
  bit ex_first;
  int ex_short, ex_long;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input int flen, input int gap, input int off, input int mx);
    c_flen = flen; c_gap = gap; c_off = off; c_max = mx;
`ifdef PERIODIC_DEFRAMER_FILL_REG_EN
    c_fill = 32'hDEADBEEF;
`else
    c_fill = 32'h0;
`endif
    fr_len.delete(); fr_eof.delete();
    in_data.delete(); in_last.delete(); in_eof.delete();
  endtask

  task automatic add_frame(input int len, input bit eof);
    fr_len.push_back(len);
    fr_eof.push_back(eof);
    for (int i = 0; i < len; i++) begin
      in_data.push_back($urandom);
      in_last.push_back(i == len - 1);
      in_eof.push_back((i == len - 1) ? eof : 1'($urandom_range(1)));
    end
  endtask

  function automatic void push_exp(input logic [31:0] d, input bit l);
    ex_data.push_back(d);
    ex_last.push_back(l);
    ex_trig.push_back(ex_first);
    ex_first = 1'b0;
  endfunction

  // Expected sample stream, built frame by frame from the burst rules.
  function automatic void build_model();
    int pos = 0;
    int k = 0;
    bit new_burst = 1'b1;
    int fl = (c_flen == 0) ? 1 : c_flen;
    ex_data.delete(); ex_last.delete(); ex_trig.delete();
    ex_short = 0; ex_long = 0; ex_first = 1'b0;
    foreach (fr_len[f]) begin
      int  len = fr_len[f];
      bit  lim, bend, known;
      if (new_burst) begin
        k = 0;
        ex_first = 1'b1;
        for (int i = 0; i < c_off; i++) push_exp(c_fill, 1'b0);
      end
      k++;
      lim   = (c_max != 0) && (k >= c_max);
      bend  = fr_eof[f] || lim;
      known = (len > fl) ? lim : bend;
      for (int i = 0; i < fl; i++)
        push_exp((i < len) ? in_data[pos + i] : c_fill,
                 (i == fl - 1) && ((c_gap == 0) || known));
      if (!bend)
        for (int g = 0; g < c_gap; g++) push_exp(c_fill, g == c_gap - 1);
      if (len < fl) ex_short++;
      if (len > fl) ex_long++;
      new_burst = bend;
      pos += len;
    end
  endfunction

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(posedge clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic program_cfg();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    wr(8'd0, 32'(c_flen));
    wr(8'd1, 32'(c_gap));
    wr(8'd2, 32'(c_off));
    wr(8'd3, 32'(c_max));
    wr(8'd4, 32'hDEADBEEF);
  endtask

  task automatic run_case(input string name, input int stall_pct, input int bubble_pct,
                          input int reset_at, output int got);
    int  cyc = 0;
    int  budget;
    int  n_s = 0;
    int  n_l = 0;
    bit  pstall = 1'b0;
    logic [31:0] pd = 32'd0;
    bit  pl = 1'b0;
    bit  in_acc;
    build_model();
    program_cfg();
    budget = 8 * (ex_data.size() + in_data.size()) + 100;
    got = 0;
    while ((in_data.size() > 0 || ex_data.size() > 0) && cyc < budget) begin
      if (!s_in.tvalid && in_data.size() > 0 && $urandom_range(99) >= bubble_pct) begin
        s_in.tvalid = 1'b1;
        s_in.tdata  = in_data[0];
        s_in.tlast  = in_last[0];
        s_in.eof    = in_eof[0];
      end
      s_out.tready = ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      if (err_short) n_s++;
      if (err_long) n_l++;
      if (pstall) begin
        chk({name, "_hold_valid"}, 32'(s_out.tvalid), 32'd1);
        chk({name, "_hold_data"}, s_out.tdata, pd);
        chk({name, "_hold_last"}, 32'(s_out.tlast), 32'(pl));
      end
      if (s_out.tvalid && s_out.tready) begin
        chk({name, "_trig_tvalid"}, 32'(trig_tvalid), 32'd1);
        if (ex_data.size() == 0) begin
          chk({name, "_extra_beat"}, 32'd1, 32'd0);
        end else begin
          chk($sformatf("%s_data[%0d]", name, got), s_out.tdata, ex_data[0]);
          chk($sformatf("%s_last[%0d]", name, got), 32'(s_out.tlast), 32'(ex_last[0]));
          chk($sformatf("%s_trig[%0d]", name, got), 32'(trig_tlast), 32'(ex_trig[0]));
          void'(ex_data.pop_front()); void'(ex_last.pop_front()); void'(ex_trig.pop_front());
        end
        got++;
      end
      pstall = s_out.tvalid && !s_out.tready;
      pd = s_out.tdata;
      pl = s_out.tlast;
      in_acc = s_in.tvalid && s_in.tready;
      if (reset_at > 0 && got == reset_at) begin
        #2 reset_n = 1'b0;
        #1;
        chk({name, "_rst_tvalid"}, 32'(s_out.tvalid), 32'd0);
        chk({name, "_rst_tlast"}, 32'(s_out.tlast), 32'd0);
        chk({name, "_rst_trig"}, 32'(trig_tlast), 32'd0);
        chk({name, "_rst_in_tready"}, 32'(s_in.tready), 32'd0);
        chk({name, "_rst_err"}, 32'(err_short | err_long), 32'd0);
        s_in.tvalid = 1'b0;
        in_data.delete(); in_last.delete(); in_eof.delete();
        return;
      end
      @(posedge clk); #1;
      if (in_acc) begin
        void'(in_data.pop_front()); void'(in_last.pop_front()); void'(in_eof.pop_front());
        s_in.tvalid = 1'b0;
      end
      cyc++;
    end
    chk({name, "_missing_beats"}, 32'(ex_data.size()), 32'd0);
    chk({name, "_unsent_input"}, 32'(in_data.size()), 32'd0);
    s_out.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (err_short) n_s++;
      if (err_long) n_l++;
      chk({name, "_idle_tvalid"}, 32'(s_out.tvalid), 32'd0);
    end
    chk({name, "_err_short_cnt"}, 32'(n_s), 32'(ex_short));
    chk({name, "_err_long_cnt"}, 32'(n_l), 32'(ex_long));
    @(posedge clk); #1;
  endtask

  initial begin
    int got;
    s_in.tvalid = 1'b0; s_in.tdata = '0; s_in.tlast = 1'b0; s_in.eof = 1'b0;
    s_out.tready = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tvalid", 32'(s_out.tvalid), 32'd0);
    chk("reset_tlast", 32'(s_out.tlast), 32'd0);
    chk("reset_in_tready", 32'(s_in.tready), 32'd0);
    chk("reset_trig", 32'(trig_tvalid | trig_tlast), 32'd0);
    chk("reset_err", 32'(err_short | err_long), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic burst: 3 fill, 4 data, 2 gap, 4 data.
    set_cfg(4, 2, 3, 0); add_frame(4, 1'b0); add_frame(4, 1'b1);
    run_case("s1", 0, 0, 0, got);
    chk("s1_beats", 32'(got), 32'd13);

    // Same burst under random backpressure and input bubbles.
    set_cfg(4, 2, 3, 0); add_frame(4, 1'b0); add_frame(4, 1'b1);
    run_case("s1bp", 40, 30, 0, got);
    chk("s1bp_beats", 32'(got), 32'd13);

    // Short frame gets padded.
    set_cfg(4, 2, 0, 0); add_frame(2, 1'b1);
    run_case("short", 20, 0, 0, got);
    chk("short_beats", 32'(got), 32'd4);

    // Long frame gets truncated, next frame is clean.
    set_cfg(4, 1, 1, 0); add_frame(6, 1'b0); add_frame(4, 1'b1);
    run_case("long", 20, 20, 0, got);
    chk("long_beats", 32'(got), 32'd10);

    // Frame limit ends the burst; the 4th frame starts a new one.
    set_cfg(4, 1, 2, 3); add_frame(4, 1'b0); add_frame(4, 1'b0); add_frame(4, 1'b0);
    add_frame(3, 1'b1);
    run_case("nmax", 25, 10, 0, got);
    chk("nmax_beats", 32'(got), 32'd22);

    // frame_len of zero behaves as one, gap of zero.
    set_cfg(0, 0, 0, 0); add_frame(1, 1'b0); add_frame(3, 1'b1);
    run_case("flen0", 0, 0, 0, got);
    chk("flen0_beats", 32'(got), 32'd2);

    // Asynchronous reset in the middle of the gap.
    set_cfg(4, 2, 3, 0); add_frame(4, 1'b0); add_frame(4, 1'b1);
    run_case("rstgap", 0, 0, 8, got);
    repeat (2) @(posedge clk);
    #1;
    chk("rstgap_hold_tvalid", 32'(s_out.tvalid), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    set_cfg(4, 2, 3, 0); add_frame(4, 1'b1);
    run_case("after_rst", 0, 0, 0, got);
    chk("after_rst_beats", 32'(got), 32'd7);

    // Randomised configurations and frame mixes.
    for (int r = 0; r < 8; r++) begin
      int nf;
      set_cfg($urandom_range(6), $urandom_range(3), $urandom_range(3), $urandom_range(4));
      nf = 1 + $urandom_range(4);
      for (int f = 0; f < nf; f++)
        add_frame(1 + $urandom_range(7), (f == nf - 1) ? 1'b1 : ($urandom_range(99) < 15));
      run_case($sformatf("rnd%0d", r), 30, 20, 0, got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
